data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_if.sv | 21 ++
 rtl/data_mem_responder.sv | 126 ++++++++++++
 tb/tb_data_mem_responder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the EX/MEM pipeline register and the data-memory responder.
interface data_mem_responder_if;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        done_o;
  logic        err_o;

  modport master (
    output MemRead_i, MemWrite_i, addr_i, wdata_i,
    input  rdata_o, stall_o, done_o, err_o
  );

  modport slave (
    input  MemRead_i, MemWrite_i, addr_i, wdata_i,
    output rdata_o, stall_o, done_o, err_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency word data memory for the MEM stage; stalls the pipeline until each access completes.
// Optional misaligned-access trap is enabled by defining DMEM_MISALIGN_TRAP_EN.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  data_mem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_wdata;
  logic               r_opWrite;
  logic [31:0]        r_rdata;
  logic               r_done;
  logic [31:0]        r_mem [DEPTH_WORDS];

  logic               w_req;
  logic               w_accept;
  logic               w_enterDone;
  logic               w_opWrite;
  logic [IDX_W-1:0]   w_idx;
  logic [31:0]        w_wdata;
  logic               w_misalign;
  logic               w_memWe;

  // With LATENCY=1 the access completes on the accept edge, so the live inputs stand in for the latched copy.
  assign w_req       = bus.MemRead_i | bus.MemWrite_i;
  assign w_accept    = (r_state == IDLE) && w_req;
  assign w_enterDone = (w_accept && (LATENCY == 1)) ||
                       ((r_state == BUSY) && (r_cnt == CNT_W'(1)));
  assign w_opWrite   = (r_state == IDLE) ? bus.MemWrite_i : r_opWrite;
  assign w_idx       = (r_state == IDLE) ? bus.addr_i[IDX_W+1:2] : r_idx;
  assign w_wdata     = (r_state == IDLE) ? bus.wdata_i : r_wdata;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic r_misalign;
  logic r_err;
  assign w_misalign = (r_state == IDLE) ? (bus.addr_i[1:0] != 2'b00) : r_misalign;
  assign bus.err_o  = r_err;
`else
  assign w_misalign = 1'b0;
  assign bus.err_o  = 1'b0;
`endif

  assign w_memWe     = !rst_i && w_enterDone && w_opWrite && !w_misalign;
  assign bus.stall_o = !rst_i && (w_accept || (r_state == BUSY));
  assign bus.rdata_o = r_rdata;
  assign bus.done_o  = r_done;

  always_ff @(posedge clk_i) begin
    if (w_memWe) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_opWrite <= 1'b0;
      r_rdata   <= '0;
      r_done    <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_done <= w_enterDone;
`ifdef DMEM_MISALIGN_TRAP_EN
      r_err <= w_enterDone && w_misalign;
`endif
      if (w_enterDone && !w_opWrite && !w_misalign) begin
        r_rdata <= r_mem[w_idx];
      end
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_idx     <= bus.addr_i[IDX_W+1:2];
            r_wdata   <= bus.wdata_i;
            r_opWrite <= bus.MemWrite_i;
`ifdef DMEM_MISALIGN_TRAP_EN
            r_misalign <= (bus.addr_i[1:0] != 2'b00);
`endif
            if (LATENCY == 1) begin
              r_state <= DONE;
            end else begin
              r_state <= BUSY;
              r_cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state <= DONE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        // The held request is still on the inputs here, so it must not be re-accepted.
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus queues expected completions, a monitor checks each done pulse.
module tb_data_mem_responder;

  localparam int LAT = 3;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   assertCount = 0;
  int   failCount   = 0;
  exp_t expQ[$];

  data_mem_responder_if bus ();

  data_mem_responder #(
    .DEPTH_WORDS(256),
    .LATENCY    (LAT)
  ) dut (
    .clk_i(clock),
    .rst_i(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Issues one request held until its DONE cycle, checking the stall window along the way.
  task automatic applyStimulus(input string name, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expRdata, input logic expErr);
    exp_t e;
    e.name  = name;
    e.rdata = expRdata;
    e.err   = expErr;
    expQ.push_back(e);
    bus.MemRead_i  = rd;
    bus.MemWrite_i = wr;
    bus.addr_i     = addr;
    bus.wdata_i    = wdata;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clock);
      checkOutput({name, " stall"}, {31'b0, bus.stall_o}, 32'd1);
      checkOutput({name, " early done"}, {31'b0, bus.done_o}, 32'd0);
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    checkOutput({name, " done"}, {31'b0, bus.done_o}, 32'd1);
    checkOutput({name, " stall in done"}, {31'b0, bus.stall_o}, 32'd0);
    @(posedge clock);
    #1;
    bus.MemRead_i  = 1'b0;
    bus.MemWrite_i = 1'b0;
    bus.addr_i     = '0;
    bus.wdata_i    = '0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.done_o === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected done", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput({e.name, " rdata"}, bus.rdata_o, e.rdata);
          checkOutput({e.name, " err"}, {31'b0, bus.err_o}, {31'b0, e.err});
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin : stimulus
    bus.MemRead_i  = 1'b0;
    bus.MemWrite_i = 1'b0;
    bus.addr_i     = '0;
    bus.wdata_i    = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput("idle stall", {31'b0, bus.stall_o}, 32'd0);
      checkOutput("idle done", {31'b0, bus.done_o}, 32'd0);
      checkOutput("idle rdata", bus.rdata_o, 32'd0);
      checkOutput("idle err", {31'b0, bus.err_o}, 32'd0);
      @(posedge clock);
      #1;
    end

    applyStimulus("store 0x10", 1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
    applyStimulus("load 0x10",  1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
    applyStimulus("store 0x400",1'b0, 1'b1, 32'h400, 32'h12345678, 32'hDEADBEEF, 1'b0);
    applyStimulus("load 0x000", 1'b1, 1'b0, 32'h0,   32'h0,        32'h12345678, 1'b0);
    applyStimulus("both 0x20",  1'b1, 1'b1, 32'h20,  32'hA5A5A5A5, 32'h12345678, 1'b0);
    applyStimulus("load 0x20",  1'b1, 1'b0, 32'h20,  32'h0,        32'hA5A5A5A5, 1'b0);
    applyStimulus("store 0x30", 1'b0, 1'b1, 32'h30,  32'h0BADF00D, 32'hA5A5A5A5, 1'b0);

    // Store of 0x1 aborted by reset in its second BUSY cycle.
    bus.MemWrite_i = 1'b1;
    bus.addr_i     = 32'h30;
    bus.wdata_i    = 32'h1;
    @(negedge clock);
    checkOutput("abort accept stall", {31'b0, bus.stall_o}, 32'd1);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset          = 1'b0;
    bus.MemWrite_i = 1'b0;
    bus.addr_i     = '0;
    bus.wdata_i    = '0;
    @(negedge clock);
    checkOutput("abort stall", {31'b0, bus.stall_o}, 32'd0);
    checkOutput("abort done", {31'b0, bus.done_o}, 32'd0);
    checkOutput("abort rdata", bus.rdata_o, 32'd0);
    @(posedge clock);
    #1;

    applyStimulus("load 0x30 after abort", 1'b1, 1'b0, 32'h30, 32'h0, 32'h0BADF00D, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    applyStimulus("misaligned store 0x22", 1'b0, 1'b1, 32'h22, 32'hFFFFFFFF, 32'h0BADF00D, 1'b1);
    applyStimulus("load 0x20 after misaligned", 1'b1, 1'b0, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0);
`else
    applyStimulus("misaligned store 0x22", 1'b0, 1'b1, 32'h22, 32'hFFFFFFFF, 32'h0BADF00D, 1'b0);
    applyStimulus("load 0x20 after misaligned", 1'b1, 1'b0, 32'h20, 32'h0, 32'hFFFFFFFF, 1'b0);
`endif

    repeat (3) @(posedge clock);
    #1;
    checkOutput("pending completions", expQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
